// File: rtl/conv_addr_gen.sv
// KxK stride-1 convolution window address sequencer: walks kc, kr, ocol, orow
// (innermost first) and issues one feature-memory read per tap under valid/ready.
module conv_addr_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start_conv,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic              o_tap_first,
    output logic              o_tap_last,
    output logic [ADDR_W-1:0] o_out_idx,
    output logic              o_busy,
    output logic              o_conv_done
);

    localparam logic [ADDR_W-1:0] C_KM1  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] C_OWM1 = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] C_OHM1 = ADDR_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0] C_W    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] C_OW   = ADDR_W'(IMG_W - K + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_kc, r_kr, r_ocol, r_orow;

    logic w_run, w_xfer, w_kc_wrap, w_kr_wrap, w_ocol_wrap, w_orow_wrap, w_final;
    logic [ADDR_W-1:0] w_addr, w_idx;

    assign w_run       = (r_state == S_RUN);
    assign w_xfer      = w_run && i_rd_ready;
    assign w_kc_wrap   = (r_kc == C_KM1);
    assign w_kr_wrap   = (r_kr == C_KM1);
    assign w_ocol_wrap = (r_ocol == C_OWM1);
    assign w_orow_wrap = (r_orow == C_OHM1);
    assign w_final     = w_kc_wrap && w_kr_wrap && w_ocol_wrap && w_orow_wrap;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_kc    <= '0;
            r_kr    <= '0;
            r_ocol  <= '0;
            r_orow  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start_conv) begin
                        r_state <= S_RUN;
                        r_kc    <= '0;
                        r_kr    <= '0;
                        r_ocol  <= '0;
                        r_orow  <= '0;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        // Every counter wraps to zero on the final tap, so the next start
                        // finds them clean even without the explicit clear.
                        r_kc <= w_kc_wrap ? '0 : r_kc + 1'b1;
                        if (w_kc_wrap)
                            r_kr <= w_kr_wrap ? '0 : r_kr + 1'b1;
                        if (w_kc_wrap && w_kr_wrap)
                            r_ocol <= w_ocol_wrap ? '0 : r_ocol + 1'b1;
                        if (w_kc_wrap && w_kr_wrap && w_ocol_wrap)
                            r_orow <= w_orow_wrap ? '0 : r_orow + 1'b1;
                        if (w_final)
                            r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_addr = (r_orow + r_kr) * C_W + r_ocol + r_kc;
    assign w_idx  = r_orow * C_OW + r_ocol;

    // Tap outputs are forced to zero outside RUN so downstream never sees stale data.
    assign o_rd_valid  = w_run;
    assign o_rd_addr   = w_run ? w_addr : '0;
    assign o_out_idx   = w_run ? w_idx : '0;
    assign o_tap_first = w_run && (r_kc == '0) && (r_kr == '0);
    assign o_tap_last  = w_run && w_kc_wrap && w_kr_wrap;
    assign o_busy      = (r_state != S_IDLE);
    assign o_conv_done = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_addr_gen.sv
// Bench for conv_addr_gen: a tap-list model derived from window arithmetic checks both
// a default and a 5x4/K=2 instance every cycle, plus literal checks from hand-worked sweeps.
module tb_conv_addr_gen;

    typedef struct {
        int addr;
        bit first;
        bit last;
        int idx;
    } tap_t;

    logic clk = 1'b0;
    logic rst, sa, sb, ra, rb;
    logic [5:0] a_addr, a_idx;
    logic [4:0] b_addr, b_idx;
    logic a_v, a_f, a_l, a_busy, a_done;
    logic b_v, b_f, b_l, b_busy, b_done;

    int tests = 0, fails = 0, cyc = 0;
    int mst[2], tix[2], startc[2], donec[2], ndone[2];
    tap_t logA[$], logB[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_addr_gen u_a (
        .i_clk(clk), .i_rst(rst), .i_start_conv(sa), .o_rd_addr(a_addr), .o_rd_valid(a_v),
        .i_rd_ready(ra), .o_tap_first(a_f), .o_tap_last(a_l), .o_out_idx(a_idx),
        .o_busy(a_busy), .o_conv_done(a_done)
    );

    conv_addr_gen #(.IMG_W(5), .IMG_H(4), .K(2), .ADDR_W(5)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start_conv(sb), .o_rd_addr(b_addr), .o_rd_valid(b_v),
        .i_rd_ready(rb), .o_tap_first(b_f), .o_tap_last(b_l), .o_out_idx(b_idx),
        .o_busy(b_busy), .o_conv_done(b_done)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    function automatic int ntap(input int d);
        int w, h, k;
        w = d ? 5 : 8; h = d ? 4 : 8; k = d ? 2 : 3;
        return (w - k + 1) * (h - k + 1) * k * k;
    endfunction

    // Decompose a linear tap number into window/kernel coordinates.
    function automatic tap_t tap_at(input int d, input int n);
        int w, k, ow, kc, kr, win, oc, orw;
        tap_t t;
        w = d ? 5 : 8; k = d ? 2 : 3; ow = w - k + 1;
        kc = n % k; kr = (n / k) % k; win = n / (k * k);
        oc = win % ow; orw = win / ow;
        t.addr = (orw + kr) * w + oc + kc;
        t.first = (kr == 0) && (kc == 0);
        t.last = (kr == k - 1) && (kc == k - 1);
        t.idx = orw * ow + oc;
        return t;
    endfunction

    task automatic chk_dut(input int d, input logic v, input logic f, input logic l,
                           input logic busy, input logic done, input logic [7:0] addr,
                           input logic [7:0] idx, input logic st, input logic rdy);
        logic [20:0] got, exp;
        tap_t e, g;
        got = {v, f, l, busy, done, addr, idx};
        exp = '0;
        if (!rst) begin
            if (mst[d] == 1) begin
                e = tap_at(d, tix[d]);
                exp = {1'b1, e.first, e.last, 1'b1, 1'b0, 8'(e.addr), 8'(e.idx)};
            end else if (mst[d] == 2) begin
                exp = {3'b000, 1'b1, 1'b1, 16'h0};
            end
        end
        chk(d ? "cycle_B" : "cycle_A", 32'(got), 32'(exp));
        if (done) begin
            ndone[d]++;
            donec[d] = cyc;
        end
        if (rst) begin
            mst[d] = 0;
        end else if (mst[d] == 0) begin
            if (st) begin
                mst[d] = 1; tix[d] = 0; startc[d] = cyc;
                if (d == 0) logA.delete(); else logB.delete();
            end
        end else if (mst[d] == 1) begin
            if (rdy) begin
                g.addr = int'(addr); g.first = f; g.last = l; g.idx = int'(idx);
                if (d == 0) logA.push_back(g); else logB.push_back(g);
                tix[d]++;
                if (tix[d] == ntap(d)) mst[d] = 2;
            end
        end else begin
            mst[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        chk_dut(0, a_v, a_f, a_l, a_busy, a_done, 8'(a_addr), 8'(a_idx), sa, ra);
        chk_dut(1, b_v, b_f, b_l, b_busy, b_done, 8'(b_addr), 8'(b_idx), sb, rb);
    end

    task automatic wait_done(input int d, input int base, input string nm);
        for (int k = 0; k < 2000 && ndone[d] <= base; k++) begin
            @(posedge clk);
            #1;
        end
        chk(nm, 32'(ndone[d] - base), 32'd1);
    endtask

    task automatic pulse_start_a;
        @(posedge clk); #1 sa = 1'b1;
        @(posedge clk); #1 sa = 1'b0;
    endtask

    initial begin
        int first9[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        int nf, base;
        for (int d = 0; d < 2; d++) begin
            mst[d] = 0; tix[d] = 0; startc[d] = 0; donec[d] = 0; ndone[d] = 0;
        end
        rst = 1'b1; sa = 1'b0; sb = 1'b0; ra = 1'b1; rb = 1'b1;
        #3;
        chk("reset_A_outputs", 32'({a_v, a_f, a_l, a_busy, a_done, a_addr, a_idx}), 32'd0);
        chk("reset_B_outputs", 32'({b_v, b_f, b_l, b_busy, b_done, b_addr, b_idx}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic sweep on both instances together
        #1 sa = 1'b1; sb = 1'b1;
        @(posedge clk); #1 sa = 1'b0; sb = 1'b0;
        wait_done(1, 0, "B_done");
        chk("B_taps", 32'(logB.size()), 32'd48);
        if (logB.size() == 48) begin
            chk("B_last_addr", 32'(logB[47].addr), 32'd19);
            chk("B_last_idx", 32'(logB[47].idx), 32'd11);
            chk("B_win2_addr", 32'(logB[4].addr), 32'd1);
            chk("B_win2_first", 32'(logB[4].first), 32'd1);
        end
        chk("B_done_latency", 32'(donec[1] - startc[1]), 32'd49);

        wait_done(0, 0, "A_done");
        chk("A_taps", 32'(logA.size()), 32'd324);
        if (logA.size() == 324) begin
            nf = 0;
            for (int i = 0; i < 9; i++) begin
                chk("A_first9_addr", 32'(logA[i].addr), 32'(first9[i]));
                chk("A_first9_idx", 32'(logA[i].idx), 32'd0);
                nf += logA[i].first;
            end
            chk("A_first_count", 32'(nf), 32'd1);
            chk("A_first_on0", 32'(logA[0].first), 32'd1);
            chk("A_last_on18", 32'(logA[8].last), 32'd1);
            chk("A_last_not17", 32'(logA[7].last), 32'd0);
            chk("A_tap10_addr", 32'(logA[9].addr), 32'd1);
            chk("A_tap10_idx", 32'(logA[9].idx), 32'd1);
            chk("A_tap10_first", 32'(logA[9].first), 32'd1);
            chk("A_end_addr", 32'(logA[323].addr), 32'd63);
            chk("A_end_idx", 32'(logA[323].idx), 32'd35);
        end
        chk("A_done_latency", 32'(donec[0] - startc[0]), 32'd325);
        @(posedge clk); #1;
        chk("A_idle_busy", 32'(a_busy), 32'd0);

        // Backpressure: hold ready low for 3 cycles on address 9
        pulse_start_a();
        for (int k = 0; k < 50 && !(a_v && a_addr == 6'd9); k++) begin
            @(posedge clk); #1;
        end
        chk("bp_reach_9", 32'(a_addr), 32'd9);
        ra = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_addr", 32'(a_addr), 32'd9);
            chk("bp_hold_flags", 32'({a_v, a_f, a_l, a_idx}), 32'({1'b1, 1'b0, 1'b0, 6'd0}));
        end
        ra = 1'b1;
        wait_done(0, 1, "bp_done");
        if (logA.size() > 5) begin
            chk("bp_tap4", 32'(logA[4].addr), 32'd9);
            chk("bp_tap5", 32'(logA[5].addr), 32'd10);
        end
        chk("bp_latency", 32'(donec[0] - startc[0]), 32'd328);

        // Start pulses at tap 50 and during DONE are ignored
        repeat (2) @(posedge clk);
        pulse_start_a();
        for (int k = 0; k < 200 && logA.size() < 50; k++) begin
            @(posedge clk); #1;
        end
        sa = 1'b1;
        @(posedge clk); #1 sa = 1'b0;
        base = ndone[0];
        for (int k = 0; k < 1000 && !a_done; k++) begin
            @(posedge clk); #1;
        end
        chk("ign_done_seen", 32'(a_done), 32'd1);
        sa = 1'b1;
        @(posedge clk); #1 sa = 1'b0;
        chk("ign_idle_after", 32'({a_busy, a_v}), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("ign_single_done", 32'(ndone[0] - base), 32'd1);
        chk("ign_taps", 32'(logA.size()), 32'd324);
        chk("ign_latency", 32'(donec[0] - startc[0]), 32'd325);
        chk("ign_stays_idle", 32'(a_busy), 32'd0);

        // Asynchronous reset in the middle of a sweep, then a clean restart
        pulse_start_a();
        for (int k = 0; k < 300 && logA.size() < 100; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 32'({a_v, a_f, a_l, a_busy, a_done, a_addr, a_idx}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        base = ndone[0];
        pulse_start_a();
        wait_done(0, base, "rst_restart_done");
        chk("rst_restart_taps", 32'(logA.size()), 32'd324);
        if (logA.size() > 0) chk("rst_restart_addr0", 32'(logA[0].addr), 32'd0);
        chk("rst_restart_latency", 32'(donec[0] - startc[0]), 32'd325);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_addr_gen.md
# conv_addr_gen

Sequencer that sits directly downstream of the accelerator controller. It consumes the `start_conv` pulse and sweeps a KxK convolution window (stride 1, no padding) over an IMG_H x IMG_W input feature map. For each tap it issues one feature-memory read address to the MAC datapath, with first/last-tap markers so the MAC can clear and commit its accumulator. It reports completion with a one-cycle `conv_done` pulse.

## Interface
- `IMG_W`, default 8: input feature-map width in pixels.
- `IMG_H`, default 8: input feature-map height in pixels.
- `K`, default 3: kernel size. Requires K <= IMG_W and K <= IMG_H.
- `ADDR_W`, default 6: address width. Requires 2**ADDR_W >= IMG_W*IMG_H.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_conv`  in  1  start request; sampled only in IDLE.
- `rd_addr`  out  ADDR_W  feature-memory read address for the current tap.
- `rd_valid`  out  1  `rd_addr` and the tap flags are valid.
- `rd_ready`  in  1  downstream accepts the current tap.
- `tap_first`  out  1  current tap is the first tap (kr=0, kc=0) of a window.
- `tap_last`  out  1  current tap is the last tap (kr=K-1, kc=K-1) of a window.
- `out_idx`  out  ADDR_W  output pixel index of the current window, orow*OW+ocol.
- `busy`  out  1  high in RUN and DONE.
- `conv_done`  out  1  one-cycle pulse when the whole map has been issued.

## Operation
- Derived sizes: OW = IMG_W-K+1 and OH = IMG_H-K+1.
- Counters:
  - kc and kr each count 0..K-1.
  - ocol counts 0..OW-1.
  - orow counts 0..OH-1.
  - Nesting order, innermost first: kc, kr, ocol, orow.
- Address: rd_addr = (orow+kr)*IMG_W + (ocol+kc), computed at ADDR_W bits. No overflow is possible given the parameter constraints.
- Handshake: a tap transfers on any cycle with rd_valid && rd_ready.
  - Counters advance only on a transfer.
  - While rd_ready is low, rd_addr, tap_first, tap_last and out_idx hold stable.
- Counter carries on a transfer:
  - kc wraps at K-1 and increments kr.
  - kr wraps and increments ocol.
  - ocol wraps and increments orow.
- State machine: IDLE, RUN, DONE.
  - IDLE: rd_valid=0. start_conv=1 moves to RUN and zeroes all counters.
  - RUN: rd_valid=1. A transfer on the final tap (orow=OH-1, ocol=OW-1, kr=K-1, kc=K-1) moves to DONE.
  - DONE: conv_done=1 and rd_valid=0 for exactly one cycle, then unconditionally back to IDLE.
- start_conv is ignored in RUN and DONE; no queuing.
- Reset (asynchronous, any time, including mid-sweep) forces:
  - state to IDLE and all counters to 0;
  - rd_valid, tap_first, tap_last, busy and conv_done to 0;
  - rd_addr and out_idx to 0.
- tap_first, tap_last and out_idx are qualified by rd_valid and read 0 outside RUN.

## Timing
- Start latency: start_conv high at edge N puts RUN in effect from N+1, with rd_valid=1 and rd_addr=0 in that cycle.
- Outputs are decoded combinationally from registered state and counters. There is no combinational path from rd_ready to any output.
- Total taps: OH*OW*K*K, which is 324 at the defaults.
- Throughput: with rd_ready held high, RUN lasts exactly OH*OW*K*K cycles. Each low cycle of rd_ready inside RUN adds one cycle.
- conv_done is asserted in the cycle after the final transfer. IDLE is re-entered one cycle later.
- The earliest accepted restart is a start_conv seen in the first IDLE cycle after DONE.

## Test plan
- Reset values: assert rst mid-cycle -> all outputs read 0 immediately, independent of clk; state is IDLE.
- Basic sweep, defaults, rd_ready=1:
  - First nine addresses are 0,1,2,8,9,10,16,17,18.
  - tap_first is set only on addr 0; tap_last is set only on addr 18; out_idx=0 throughout.
  - The tenth address is 1, with out_idx=1 and tap_first=1.
  - The last address is 63, with out_idx=35.
  - conv_done fires exactly 325 cycles after start_conv is sampled.
- Backpressure: drop rd_ready for 3 cycles while addr=9 -> addr stays 9 and flags hold; the sequence resumes with 10; conv_done arrives 3 cycles later than in the basic sweep.
- Ignored start: pulse start_conv at tap 50 and during the DONE cycle -> no counter reset, a single conv_done, then return to IDLE.
- Reset mid-sweep: assert rst at tap 100, release, then start -> the sweep restarts from addr 0 and completes in 324 cycles.
- Parameter variant, IMG_W=5, IMG_H=4, K=2: 12 windows and 48 taps; last addr 19; the second window's first tap is addr 1; conv_done follows the 48th transfer.
